// File: rtl/synth_pkg.sv
// Shared types, default widths and helpers for the voice scheduler slice.
package synth_pkg;

  localparam int NUM_VOICES_DEF = 4;
  localparam int FREQ_W_DEF     = 24;
  localparam int DATA_W_DEF     = 16;
  localparam int KEY_W_DEF      = 8;

  // Scan FSM states of the time-multiplexed wavetable scheduler.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // One voice table slot at the default widths (age is log2(NUM_VOICES) bits).
  typedef struct packed {
    logic                              active;
    logic [KEY_W_DEF-1:0]              key_code;
    logic [FREQ_W_DEF-1:0]             freq;
    logic [$clog2(NUM_VOICES_DEF)-1:0] age;
  } voice_entry_t;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x,
                                                    input int w);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (w - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (w - 1));
    if (x > max_v)      sat_signed = max_v;
    else if (x < min_v) sat_signed = min_v;
    else                sat_signed = x;
  endfunction

endpackage

// File: rtl/voice_alloc.sv
// Voice table: note-on allocation / stealing, note-off release, age tracking,
// plus a frequency read port indexed by the scheduler's scan position.
module voice_alloc
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int FREQ_W     = FREQ_W_DEF,
  parameter int KEY_W      = KEY_W_DEF
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          key_valid,
  input  logic                          key_on,
  input  logic [KEY_W-1:0]              key_code,
  input  logic [FREQ_W-1:0]             key_freq,
  input  logic [$clog2(NUM_VOICES)-1:0] rd_idx,
  output logic [FREQ_W-1:0]             rd_freq,
  output logic [NUM_VOICES-1:0]         active_mask
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] AGE_MAX = '1;
  localparam logic [IDX_W-1:0] AGE_ONE = IDX_W'(1);

  logic [NUM_VOICES-1:0] active_reg;
  logic [NUM_VOICES-1:0] active_next;
  logic [KEY_W-1:0]      key_reg   [NUM_VOICES];
  logic [KEY_W-1:0]      key_next  [NUM_VOICES];
  logic [FREQ_W-1:0]     freq_reg  [NUM_VOICES];
  logic [FREQ_W-1:0]     freq_next [NUM_VOICES];
  logic [IDX_W-1:0]      age_reg   [NUM_VOICES];
  logic [IDX_W-1:0]      age_next  [NUM_VOICES];

  logic             match_hit;
  logic [IDX_W-1:0] match_idx;
  logic             free_hit;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] steal_idx;
  logic [IDX_W-1:0] best_age;
  logic [IDX_W-1:0] alloc_idx;

  // Locate the matching active key, the lowest free slot and the oldest slot.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    steal_idx = '0;
    best_age  = age_reg[0];
    // Descending scan so the lowest index is the one left standing.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active_reg[i] && (key_reg[i] == key_code)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!active_reg[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    // Strictly-greater comparison keeps the lowest index on age ties.
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_reg[i] > best_age) begin
        best_age  = age_reg[i];
        steal_idx = IDX_W'(i);
      end
    end
  end

  // Apply the key event to produce the next voice table contents.
  always_comb begin
    active_next = active_reg;
    for (int i = 0; i < NUM_VOICES; i++) begin
      key_next[i]  = key_reg[i];
      freq_next[i] = freq_reg[i];
      age_next[i]  = age_reg[i];
    end
    alloc_idx = free_hit ? free_idx : steal_idx;
    if (key_valid) begin
      if (key_on) begin
        if (match_hit) begin
          // Retrigger of a sounding key only retunes it.
          freq_next[match_idx] = key_freq;
        end else begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == alloc_idx) begin
              active_next[i] = 1'b1;
              key_next[i]    = key_code;
              freq_next[i]   = key_freq;
              age_next[i]    = '0;
            end else if (active_reg[i] && (age_reg[i] != AGE_MAX)) begin
              age_next[i] = age_reg[i] + AGE_ONE;
            end
          end
        end
      end else if (match_hit) begin
        active_next[match_idx] = 1'b0;
      end
    end
  end

  // Voice table state register.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      active_reg <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        key_reg[i]  <= '0;
        freq_reg[i] <= '0;
        age_reg[i]  <= '0;
      end
    end else begin
      active_reg <= active_next;
      for (int i = 0; i < NUM_VOICES; i++) begin
        key_reg[i]  <= key_next[i];
        freq_reg[i] <= freq_next[i];
        age_reg[i]  <= age_next[i];
      end
    end
  end

  assign rd_freq = freq_reg[rd_idx];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_mask
      assign active_mask[gi] = active_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: per sample tick, walks the voice table, issues
// one wavetable lookup per active voice, sums the results and emits one
// saturated mixed sample.
module voice_scheduler
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int FREQ_W     = FREQ_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int KEY_W      = KEY_W_DEF
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          key_valid,
  input  logic                          key_on,
  input  logic [KEY_W-1:0]              key_code,
  input  logic [FREQ_W-1:0]             key_freq,
  input  logic                          sample_tick,
  output logic                          wt_req,
  output logic [$clog2(NUM_VOICES)-1:0] wt_voice,
  output logic [FREQ_W-1:0]             wt_freq,
  input  logic                          wt_ack,
  input  logic [DATA_W-1:0]             wt_data,
  output logic [DATA_W-1:0]             mix_out,
  output logic                          mix_valid,
  output logic [NUM_VOICES-1:0]         active_mask,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = DATA_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_V  = IDX_W'(NUM_VOICES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  sched_state_t            state_reg, state_next;
  logic [IDX_W-1:0]        v_reg, v_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic                    wt_req_reg, wt_req_next;
  logic [IDX_W-1:0]        wt_voice_reg, wt_voice_next;
  logic [FREQ_W-1:0]       wt_freq_reg, wt_freq_next;
  logic [DATA_W-1:0]       mix_out_reg, mix_out_next;
  logic                    mix_valid_reg, mix_valid_next;
  logic                    busy_reg, busy_next;
  logic                    overrun_reg, overrun_next;

  logic [FREQ_W-1:0]       rd_freq;
  logic signed [ACC_W-1:0] wt_data_ext;
  logic signed [31:0]      acc_wide;
  logic signed [31:0]      sat_wide;

  voice_alloc #(
    .NUM_VOICES (NUM_VOICES),
    .FREQ_W     (FREQ_W),
    .KEY_W      (KEY_W)
  ) u_alloc (
    .Clk         (Clk),
    .Reset       (Reset),
    .key_valid   (key_valid),
    .key_on      (key_on),
    .key_code    (key_code),
    .key_freq    (key_freq),
    .rd_idx      (v_reg),
    .rd_freq     (rd_freq),
    .active_mask (active_mask)
  );

  assign wt_data_ext = $signed({{IDX_W{wt_data[DATA_W-1]}}, wt_data});
  assign acc_wide    = $signed({{(32 - ACC_W){acc_reg[ACC_W-1]}}, acc_reg});
  assign sat_wide    = sat_signed(acc_wide, DATA_W);

  // Scan FSM next-state and datapath: one voice per ISSUE, hold in WAIT until ack.
  always_comb begin
    state_next     = state_reg;
    v_next         = v_reg;
    acc_next       = acc_reg;
    wt_req_next    = wt_req_reg;
    wt_voice_next  = wt_voice_reg;
    wt_freq_next   = wt_freq_reg;
    mix_out_next   = mix_out_reg;
    mix_valid_next = 1'b0;
    // A tick outside IDLE is dropped and flagged; the flag is sticky.
    overrun_next   = overrun_reg | (sample_tick && (state_reg != IDLE));
    case (state_reg)
      IDLE: begin
        if (sample_tick) begin
          acc_next   = '0;
          v_next     = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (active_mask[v_reg]) begin
          wt_voice_next = v_reg;
          wt_freq_next  = rd_freq;
          wt_req_next   = 1'b1;
          state_next    = WAIT;
        end else if (v_reg == LAST_V) begin
          state_next = DONE;
        end else begin
          v_next = v_reg + IDX_ONE;
        end
      end
      WAIT: begin
        // A note-off of this voice meanwhile does not cancel the lookup.
        if (wt_ack) begin
          acc_next    = acc_reg + wt_data_ext;
          wt_req_next = 1'b0;
          if (v_reg == LAST_V) begin
            state_next = DONE;
          end else begin
            v_next     = v_reg + IDX_ONE;
            state_next = ISSUE;
          end
        end
      end
      DONE: begin
        mix_out_next   = sat_wide[DATA_W-1:0];
        mix_valid_next = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  // Scheduler state and output registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg     <= IDLE;
      v_reg         <= '0;
      acc_reg       <= '0;
      wt_req_reg    <= 1'b0;
      wt_voice_reg  <= '0;
      wt_freq_reg   <= '0;
      mix_out_reg   <= '0;
      mix_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      v_reg         <= v_next;
      acc_reg       <= acc_next;
      wt_req_reg    <= wt_req_next;
      wt_voice_reg  <= wt_voice_next;
      wt_freq_reg   <= wt_freq_next;
      mix_out_reg   <= mix_out_next;
      mix_valid_reg <= mix_valid_next;
      busy_reg      <= busy_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign wt_req    = wt_req_reg;
  assign wt_voice  = wt_voice_reg;
  assign wt_freq   = wt_freq_reg;
  assign mix_out   = mix_out_reg;
  assign mix_valid = mix_valid_reg;
  assign busy      = busy_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: a behavioural voice table model
// predicts lookup requests and mixed samples; a responder and a mix monitor
// pop and compare independently of the stimulus.
module tb_voice_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int FW = 24;
  localparam int KW = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          key_valid;
  logic          key_on;
  logic [KW-1:0] key_code;
  logic [FW-1:0] key_freq;
  logic          sample_tick;
  logic          wt_req;
  logic [1:0]    wt_voice;
  logic [FW-1:0] wt_freq;
  logic          wt_ack;
  logic [DW-1:0] wt_data;
  logic [DW-1:0] mix_out;
  logic          mix_valid;
  logic [N-1:0]  active_mask;
  logic          busy;
  logic          overrun;

  voice_scheduler #(.NUM_VOICES(N), .FREQ_W(FW), .DATA_W(DW), .KEY_W(KW)) dut (
    .Clk(Clk), .Reset(Reset), .key_valid(key_valid), .key_on(key_on),
    .key_code(key_code), .key_freq(key_freq), .sample_tick(sample_tick),
    .wt_req(wt_req), .wt_voice(wt_voice), .wt_freq(wt_freq), .wt_ack(wt_ack),
    .wt_data(wt_data), .mix_out(mix_out), .mix_valid(mix_valid),
    .active_mask(active_mask), .busy(busy), .overrun(overrun)
  );

  always #10 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  int m_active[N];
  int m_key[N];
  int m_freq[N];
  int m_age[N];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 0; m_key[i] = 0; m_freq[i] = 0; m_age[i] = 0;
    end
  endfunction

  function automatic void model_on(input int code, input int freq);
    int tgt;
    for (int i = 0; i < N; i++)
      if (m_active[i] != 0 && m_key[i] == code) begin
        m_freq[i] = freq;
        return;
      end
    tgt = -1;
    for (int i = N - 1; i >= 0; i--) if (m_active[i] == 0) tgt = i;
    if (tgt < 0) begin
      tgt = 0;
      for (int i = 1; i < N; i++) if (m_age[i] > m_age[tgt]) tgt = i;
    end
    for (int i = 0; i < N; i++)
      if (i != tgt && m_active[i] != 0 && m_age[i] < N - 1) m_age[i]++;
    m_active[tgt] = 1; m_key[tgt] = code; m_freq[tgt] = freq; m_age[tgt] = 0;
  endfunction

  function automatic void model_off(input int code);
    for (int i = 0; i < N; i++)
      if (m_active[i] != 0 && m_key[i] == code) begin
        m_active[i] = 0;
        return;
      end
  endfunction

  function automatic int model_mask();
    int m = 0;
    for (int i = 0; i < N; i++) if (m_active[i] != 0) m += (1 << i);
    return m;
  endfunction

  function automatic int sat16(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int voice;
    int freq;
    int data;
  } req_t;

  req_t req_q[$];
  int   mix_q[$];
  int   force_q[$];
  int   ack_delay = -1;
  int   tick_cycle = 0;

  // Responder: checks each new request against the queue and acks it.
  req_t cur;
  int   resp_in_txn = 0;
  int   resp_cnt = 0;
  int   resp_orphan = 0;
  int   req_seen = 0;

  initial begin
    wt_ack  = 1'b0;
    wt_data = '0;
    forever begin
      @(negedge Clk);
      wt_ack = 1'b0;
      if (wt_req !== 1'b1) resp_orphan = 0;
      if (wt_req === 1'b1) begin
        if (resp_in_txn == 0) begin
          if (req_q.size() == 0) begin
            if (resp_orphan == 0) check("unexpected_wt_req", 1, 0);
            resp_orphan = 1;
          end else begin
            req_seen++;
            cur = req_q.pop_front();
            resp_in_txn = 1;
            check("wt_voice", wt_voice, cur.voice);
            check("wt_freq", wt_freq, cur.freq);
            resp_cnt = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
          end
        end
        if (resp_in_txn != 0) begin
          if (resp_cnt == 0) begin
            check("wt_voice_held", wt_voice, cur.voice);
            wt_ack  = 1'b1;
            wt_data = 16'(cur.data);
            resp_in_txn = 0;
          end else begin
            resp_cnt--;
          end
        end
      end
    end
  end

  // Mix monitor: each mix_valid pops one expected sample.
  int mix_seen = 0;
  int last_mix_cycle = -1;
  int last_mix_val = 0;

  initial begin
    forever begin
      @(negedge Clk);
      if (mix_valid === 1'b1) begin
        int e;
        mix_seen++;
        last_mix_cycle = cyc;
        last_mix_val = int'($signed(mix_out));
        if (mix_q.size() == 0) begin
          check("unexpected_mix_valid", 1, 0);
        end else begin
          e = mix_q.pop_front();
          check("mix_out", last_mix_val, e);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic key_event(input bit on, input int code, input int freq);
    @(posedge Clk); #1;
    key_valid = 1'b1; key_on = on; key_code = KW'(code); key_freq = FW'(freq);
    @(posedge Clk); #1;
    key_valid = 1'b0;
    if (on) model_on(code, freq);
    else    model_off(code);
    $display("key %s code=%02h freq=%06h mask=%b", on ? "on " : "off", code, freq, active_mask);
    check("active_mask", active_mask, model_mask());
  endtask

  task automatic do_tick();
    int sum;
    int d;
    req_t r;
    @(posedge Clk); #1;
    sample_tick = 1'b1;
    tick_cycle = cyc;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      if (m_active[i] != 0) begin
        if (force_q.size() != 0) d = force_q.pop_front();
        else d = int'($urandom_range(0, 65535)) - 32768;
        r.voice = i; r.freq = m_freq[i]; r.data = d;
        req_q.push_back(r);
        sum += d;
      end
    end
    mix_q.push_back(sat16(sum));
    $display("tick cycle=%0d mask=%b expect_mix=%0d", tick_cycle, active_mask, sat16(sum));
    @(posedge Clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy !== 1'b0 || mix_q.size() != 0 || req_q.size() != 0 || resp_in_txn != 0)
           && n < 3000) begin
      @(negedge Clk); #1;
      n++;
    end
    check({"scan_done_", tag}, (n < 3000) ? 1 : 0, 1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (wt_req !== 1'b1 && n < 200) begin
      @(negedge Clk); #1;
      n++;
    end
    check({"req_seen_", tag}, (n < 200) ? 1 : 0, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rs, ms, wv, nev, code;
    Reset = 1'b0; key_valid = 1'b0; key_on = 1'b0; key_code = '0; key_freq = '0;
    sample_tick = 1'b0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk); #1;
    check("rst_wt_req", wt_req, 0);
    check("rst_mix_valid", mix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_mix_out", mix_out, 0);
    check("rst_wt_voice", wt_voice, 0);
    check("rst_wt_freq", wt_freq, 0);
    check("rst_active_mask", active_mask, 0);

    // 1: empty scan latency
    rs = req_seen;
    do_tick();
    wait_idle("t1");
    check("t1_latency", last_mix_cycle - tick_cycle, 6);
    check("t1_mix", last_mix_val, 0);
    check("t1_no_req", req_seen - rs, 0);

    // 2: two voices, fixed data
    key_event(1, 'h1C, 'h00A000);
    key_event(1, 'h1D, 'h00B000);
    ack_delay = 2;
    force_q.push_back(1000);
    force_q.push_back(-300);
    do_tick();
    wait_idle("t2");
    check("t2_mix", last_mix_val, 700);
    key_event(0, 'h1C, 0);
    key_event(0, 'h1D, 0);
    ack_delay = -1;

    // 3: fifth note steals the oldest voice
    for (int k = 0; k < 5; k++) key_event(1, 'h10 + k, int'($urandom_range(0, 'hFFFFFF)));
    check("t3_mask_full", active_mask, 'hF);
    do_tick();
    wait_idle("t3");
    key_event(0, 'h14, 0);
    check("t3_steal_slot0", active_mask, 'hE);
    key_event(1, 'h15, int'($urandom_range(0, 'hFFFFFF)));

    // 4: saturation both ways
    for (int k = 0; k < 4; k++) force_q.push_back(12000);
    do_tick();
    wait_idle("t4p");
    check("t4_sat_pos", last_mix_val, 32767);
    for (int k = 0; k < 4; k++) force_q.push_back(-12000);
    do_tick();
    wait_idle("t4n");
    check("t4_sat_neg", last_mix_val, -32768);

    // 5: tick while waiting, note-off of the waited voice
    ack_delay = 6;
    ms = mix_seen;
    do_tick();
    wait_req("t5");
    wv = int'(wt_voice);
    sample_tick = 1'b1;
    @(posedge Clk); #1;
    sample_tick = 1'b0;
    @(negedge Clk); #1;
    check("t5_overrun", overrun, 1);
    key_event(0, m_key[wv], 0);
    check("t5_mask_bit_clear", active_mask[wv], 0);
    wait_idle("t5");
    check("t5_one_mix", mix_seen - ms, 1);
    check("t5_overrun_sticky", overrun, 1);

    // 6: reset while waiting
    ack_delay = 4;
    do_tick();
    wait_req("t6");
    ms = mix_seen;
    Reset = 1'b0;
    @(posedge Clk); #1;
    req_q.delete(); mix_q.delete(); force_q.delete();
    resp_in_txn = 0; wt_ack = 1'b0;
    model_reset();
    @(negedge Clk); #1;
    check("t6_wt_req", wt_req, 0);
    check("t6_mask", active_mask, 0);
    check("t6_busy", busy, 0);
    check("t6_overrun", overrun, 0);
    @(posedge Clk); #1 Reset = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    check("t6_no_mix", mix_seen - ms, 0);
    ack_delay = -1;
    // Empty scan, then a tick landing in the mix_valid cycle is accepted.
    ms = mix_seen;
    do_tick();
    repeat (4) @(posedge Clk);
    do_tick();
    wait_idle("t6b");
    check("t6_two_mix", mix_seen - ms, 2);
    check("t6_b2b_no_overrun", overrun, 0);
    check("t6_mix_zero", last_mix_val, 0);

    // Random events and scans against the model
    for (int it = 0; it < 30; it++) begin
      nev = int'($urandom_range(1, 3));
      for (int e = 0; e < nev; e++) begin
        code = 'h20 + int'($urandom_range(0, 5));
        if ($urandom_range(0, 2) != 0) key_event(1, code, int'($urandom_range(0, 'hFFFFFF)));
        else key_event(0, code, 0);
      end
      do_tick();
      wait_idle("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
